// File: rtl/vga_fill_sequencer_pkg.sv
// vga_fill_sequencer_pkg
// Shared definitions for the video RAM write-port sequencer: default geometry of
// the video RAM, the fill FSM state encoding and the clip helper used in SETUP.
// No ports; imported by vga_fill_sequencer and vga_fill_walker.
package vga_fill_sequencer_pkg;

   localparam int VGA_DATA_WIDTH = 3;
   localparam int VGA_ADDR_WIDTH = 8;
   localparam int VGA_MEM_WIDTH  = 16;
   localparam int VGA_MEM_HEIGHT = 12;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'd0,
      FILL_SETUP = 2'd1,
      FILL_RUN   = 2'd2,
      FILL_DONE  = 2'd3
   } fillState_t;

   // Exclusive end coordinate of a span, clamped to the screen edge. The sum is
   // 9 bits wide so start+len can never wrap back onto the screen.
   function automatic logic [8:0] clipEnd(input logic [7:0] start,
                                          input logic [7:0] len,
                                          input logic [8:0] limit);
      logic [8:0] sum;
      sum = {1'b0, start} + {1'b0, len};
      return (sum > limit) ? limit : sum;
   endfunction

endpackage

// File: rtl/vga_fill_walker.sv
// vga_fill_walker
// Row-major pixel walker for the rectangle fill. Holds column/row counters, the
// running row base address and the current write address.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   load_i            initialise counters from x_i/y_i and the clipped ends
//   step_i            a pixel was written this cycle; advance to the next one
//   x_i, y_i          top-left corner of the rectangle
//   xEnd_i, yEnd_i    exclusive clipped end column/row
//   addr_o            address of the pixel to be written next
//   last_o            the current pixel is the final one of the rectangle
module vga_fill_walker
   import vga_fill_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = VGA_ADDR_WIDTH,
   parameter int MEM_WIDTH  = VGA_MEM_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [7:0]            x_i,
   input  logic [7:0]            y_i,
   input  logic [8:0]            xEnd_i,
   input  logic [8:0]            yEnd_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o
);

   localparam logic [ADDR_WIDTH-1:0] RowStep = ADDR_WIDTH'(MEM_WIDTH);

   logic [7:0]            col_q, col_d;
   logic [7:0]            row_q, row_d;
   logic [7:0]            xStart_q, xStart_d;
   logic [8:0]            xEnd_q, xEnd_d;
   logic [8:0]            yEnd_q, yEnd_d;
   logic [ADDR_WIDTH-1:0] rowBase_q, rowBase_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] rowBaseLoad;
   logic                  lastCol;
   logic                  lastRow;

   assign lastCol = ({1'b0, col_q} == (xEnd_q - 9'd1));
   assign lastRow = ({1'b0, row_q} == (yEnd_q - 9'd1));
   assign last_o  = lastCol && lastRow;
   assign addr_o  = addr_q;

   // The starting row base is a constant scale of Y, computed once per fill;
   // after that each new row only adds MEM_WIDTH to the running base.
   assign rowBaseLoad = ADDR_WIDTH'(y_i * MEM_WIDTH);

   // Next-state for the counters. The address steps by one along a row and on
   // the row wrap jumps to the next row's base plus the left edge.
   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      xStart_d  = xStart_q;
      xEnd_d    = xEnd_q;
      yEnd_d    = yEnd_q;
      rowBase_d = rowBase_q;
      addr_d    = addr_q;
      if (load_i) begin
         col_d     = x_i;
         row_d     = y_i;
         xStart_d  = x_i;
         xEnd_d    = xEnd_i;
         yEnd_d    = yEnd_i;
         rowBase_d = rowBaseLoad;
         addr_d    = rowBaseLoad + ADDR_WIDTH'(x_i);
      end else if (step_i) begin
         if (lastCol) begin
            col_d     = xStart_q;
            row_d     = row_q + 8'd1;
            rowBase_d = rowBase_q + RowStep;
            addr_d    = rowBase_q + RowStep + ADDR_WIDTH'(xStart_q);
         end else begin
            col_d  = col_q + 8'd1;
            addr_d = addr_q + 1'b1;
         end
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         col_q     <= '0;
         row_q     <= '0;
         xStart_q  <= '0;
         xEnd_q    <= '0;
         yEnd_q    <= '0;
         rowBase_q <= '0;
         addr_q    <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         xStart_q  <= xStart_d;
         xEnd_q    <= xEnd_d;
         yEnd_q    <= yEnd_d;
         rowBase_q <= rowBase_d;
         addr_q    <= addr_d;
      end
   end

endmodule

// File: rtl/vga_fill_sequencer.sv
// vga_fill_sequencer
// Owns the single video RAM write port. CPU writes pass straight through with
// priority; otherwise a hardware rectangle fill paints a clipped block of one
// colour, one pixel per free cycle.
// Ports:
//   Clock, Reset                      clock, synchronous active-low reset
//   iCpuWrite/iCpuAddr/iCpuData       CPU write request
//   iFillStart/iFillColor             fill request (accepted in IDLE) and colour
//   iFillX/iFillY/iFillW/iFillH       rectangle corner and size
//   oWriteEnable/Address/Data         video RAM write port
//   oBusy                             fill in progress (SETUP, FILL, DONE)
//   oDone                             one-cycle completion pulse
module vga_fill_sequencer
   import vga_fill_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = VGA_DATA_WIDTH,
   parameter int ADDR_WIDTH = VGA_ADDR_WIDTH,
   parameter int MEM_WIDTH  = VGA_MEM_WIDTH,
   parameter int MEM_HEIGHT = VGA_MEM_HEIGHT
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iCpuWrite,
   input  logic [ADDR_WIDTH-1:0] iCpuAddr,
   input  logic [DATA_WIDTH-1:0] iCpuData,
   input  logic                  iFillStart,
   input  logic [DATA_WIDTH-1:0] iFillColor,
   input  logic [7:0]            iFillX,
   input  logic [7:0]            iFillY,
   input  logic [7:0]            iFillW,
   input  logic [7:0]            iFillH,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [DATA_WIDTH-1:0] oWriteData,
   output logic                  oBusy,
   output logic                  oDone
);

   localparam logic [8:0] MemWidth9  = 9'(MEM_WIDTH);
   localparam logic [8:0] MemHeight9 = 9'(MEM_HEIGHT);

   fillState_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] color_q, color_d;
   logic [7:0]            x_q, x_d;
   logic [7:0]            y_q, y_d;
   logic [7:0]            w_q, w_d;
   logic [7:0]            h_q, h_d;
   logic [8:0]            xEnd;
   logic [8:0]            yEnd;
   logic                  empty;
   logic                  walkerLoad;
   logic                  walkerStep;
   logic                  walkerLast;
   logic [ADDR_WIDTH-1:0] walkerAddr;

   // Clipping is evaluated from the latched request while in SETUP.
   assign xEnd  = clipEnd(x_q, w_q, MemWidth9);
   assign yEnd  = clipEnd(y_q, h_q, MemHeight9);
   assign empty = (w_q == 8'd0) || (h_q == 8'd0) ||
                  ({1'b0, x_q} >= MemWidth9) || ({1'b0, y_q} >= MemHeight9);

   vga_fill_walker #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .MEM_WIDTH (MEM_WIDTH)
   ) uWalker (
      .clk_i (Clock),
      .rst_ni(Reset),
      .load_i(walkerLoad),
      .step_i(walkerStep),
      .x_i   (x_q),
      .y_i   (y_q),
      .xEnd_i(xEnd),
      .yEnd_i(yEnd),
      .addr_o(walkerAddr),
      .last_o(walkerLast)
   );

   // Fill FSM next-state. A CPU write in FILL is a stall: the walker does not
   // step, so no pixel is lost. Starts outside IDLE are dropped, not queued.
   always_comb begin
      state_d    = state_q;
      color_d    = color_q;
      x_d        = x_q;
      y_d        = y_q;
      w_d        = w_q;
      h_d        = h_q;
      walkerLoad = 1'b0;
      walkerStep = 1'b0;
      case (state_q)
         FILL_IDLE: begin
            if (iFillStart) begin
               color_d = iFillColor;
               x_d     = iFillX;
               y_d     = iFillY;
               w_d     = iFillW;
               h_d     = iFillH;
               state_d = FILL_SETUP;
            end
         end
         FILL_SETUP: begin
            if (empty) begin
               state_d = FILL_DONE;
            end else begin
               walkerLoad = 1'b1;
               state_d    = FILL_RUN;
            end
         end
         FILL_RUN: begin
            if (!iCpuWrite) begin
               walkerStep = 1'b1;
               if (walkerLast) begin
                  state_d = FILL_DONE;
               end
            end
         end
         FILL_DONE: begin
            state_d = FILL_IDLE;
         end
         default: begin
            state_d = FILL_IDLE;
         end
      endcase
   end

   // Write-port mux: the CPU always wins, the fill only drives in FILL.
   always_comb begin
      oWriteEnable  = 1'b0;
      oWriteAddress = '0;
      oWriteData    = '0;
      if (iCpuWrite) begin
         oWriteEnable  = 1'b1;
         oWriteAddress = iCpuAddr;
         oWriteData    = iCpuData;
      end else if (state_q == FILL_RUN) begin
         oWriteEnable  = 1'b1;
         oWriteAddress = walkerAddr;
         oWriteData    = color_q;
      end
   end

   assign oBusy = (state_q != FILL_IDLE);
   assign oDone = (state_q == FILL_DONE);

   // State and latched request registers.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= FILL_IDLE;
         color_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
      end
   end

endmodule

// File: tb/tb_vga_fill_sequencer.sv
// tb_vga_fill_sequencer
// Self-checking bench for vga_fill_sequencer: a table of directed fills, a set
// of randomized fills with random CPU contention, and hand-written reset
// sequences. Expected writes come from a rectangle/clip reference model.
module tb_vga_fill_sequencer;

   localparam int MaxCycles = 1024;

   logic       Clock;
   logic       Reset;
   logic       iCpuWrite;
   logic [7:0] iCpuAddr;
   logic [2:0] iCpuData;
   logic       iFillStart;
   logic [2:0] iFillColor;
   logic [7:0] iFillX;
   logic [7:0] iFillY;
   logic [7:0] iFillW;
   logic [7:0] iFillH;
   logic       oWriteEnable;
   logic [7:0] oWriteAddress;
   logic [2:0] oWriteData;
   logic       oBusy;
   logic       oDone;

   int compared;
   int mismatched;

   typedef struct {
      int         x;
      int         y;
      int         w;
      int         h;
      logic [2:0] color;
      int         cpuMode;
      int         startAgain;
      int         expN;
      int         expDone;
   } vec_t;

   vec_t vecs[7];

   vga_fill_sequencer dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iCpuWrite    (iCpuWrite),
      .iCpuAddr     (iCpuAddr),
      .iCpuData     (iCpuData),
      .iFillStart   (iFillStart),
      .iFillColor   (iFillColor),
      .iFillX       (iFillX),
      .iFillY       (iFillY),
      .iFillW       (iFillW),
      .iFillH       (iFillH),
      .oWriteEnable (oWriteEnable),
      .oWriteAddress(oWriteAddress),
      .oWriteData   (oWriteData),
      .oBusy        (oBusy),
      .oDone        (oDone)
   );

   // 10-time-unit clock; inputs change on the falling edge.
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Single comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      iCpuWrite  = 1'b0;
      iCpuAddr   = '0;
      iCpuData   = '0;
      iFillStart = 1'b0;
      iFillColor = '0;
      iFillX     = '0;
      iFillY     = '0;
      iFillW     = '0;
      iFillH     = '0;
   endtask

   // One fill request from cycle 0 until one cycle after oDone. cpuMode:
   // 0 none, 1 single CPU write (200/7) in cycle 3, 2 random CPU traffic.
   // startAgain: 0 none, -1 random busy cycle, >0 that cycle.
   // Table entries also check the write count and done cycle against
   // hand-computed values (negative = skip).
   task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                input logic [2:0] color, input int cpuMode,
                                input int startAgain, input int expN,
                                input int expDone);
      int         expAddr[$];
      int         expCyc[$];
      bit         cpuW[MaxCycles];
      logic [7:0] cpuA[MaxCycles];
      logic [2:0] cpuD[MaxCycles];
      int         n;
      int         cyc;
      int         modelDone;
      int         sa;
      int         wi;
      int         doneSeen;
      int         xe;
      int         ye;

      // Reference rectangle: every on-screen pixel, row-major.
      xe = (x + w > 16) ? 16 : x + w;
      ye = (y + h > 12) ? 12 : y + h;
      for (int r = y; r < ye; r++) begin
         for (int c = x; c < xe; c++) begin
            expAddr.push_back(r * 16 + c);
         end
      end
      n = expAddr.size();

      for (int k = 0; k < MaxCycles; k++) begin
         cpuW[k] = 1'b0;
         cpuA[k] = 8'($urandom);
         cpuD[k] = 3'($urandom);
         if (cpuMode == 2) cpuW[k] = ($urandom_range(0, 3) == 0);
      end
      if (cpuMode == 1) begin
         cpuW[3] = 1'b1;
         cpuA[3] = 8'd200;
         cpuD[3] = 3'd7;
      end

      // Pixels go out from cycle 2, skipping every CPU-owned cycle.
      cyc = 2;
      for (int i = 0; i < n; i++) begin
         while (cpuW[cyc] && cyc < MaxCycles - 8) cyc++;
         expCyc.push_back(cyc);
         cyc++;
      end
      modelDone = (n == 0) ? 2 : cyc;

      sa = startAgain;
      if (startAgain < 0) sa = $urandom_range(1, modelDone);

      wi       = 0;
      doneSeen = -1;
      for (int k = 0; k <= modelDone + 1; k++) begin
         @(negedge Clock);
         iFillStart = (k == 0) || (k == sa);
         if (k == 0) begin
            iFillColor = color;
            iFillX     = 8'(x);
            iFillY     = 8'(y);
            iFillW     = 8'(w);
            iFillH     = 8'(h);
         end else begin
            iFillColor = 3'($urandom);
            iFillX     = 8'($urandom);
            iFillY     = 8'($urandom);
            iFillW     = 8'($urandom);
            iFillH     = 8'($urandom);
         end
         iCpuWrite = cpuW[k];
         iCpuAddr  = cpuA[k];
         iCpuData  = cpuD[k];
         #1;
         if (cpuW[k]) begin
            checkOutput("cpuPass", {20'd0, oWriteEnable, oWriteAddress, oWriteData},
                        {20'd0, 1'b1, cpuA[k], cpuD[k]});
         end else if (oWriteEnable) begin
            if (wi < n) begin
               checkOutput("fillWrite", {21'd0, oWriteAddress, oWriteData},
                           {21'd0, 8'(expAddr[wi]), color});
               checkOutput("fillCycle", k, expCyc[wi]);
            end else begin
               checkOutput("extraWrite", {24'd0, oWriteAddress}, 32'hFFFF_FFFF);
            end
            wi++;
         end
         checkOutput("busy", {31'd0, oBusy}, {31'd0, (k >= 1) && (k <= modelDone)});
         checkOutput("done", {31'd0, oDone}, {31'd0, k == modelDone});
         if (oDone && doneSeen < 0) doneSeen = k;
      end
      checkOutput("writeCount", wi, n);
      if (expN >= 0) checkOutput("tableCount", wi, expN);
      if (expDone >= 0) checkOutput("tableDone", doneSeen, expDone);
      idleInputs();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      Reset      = 1'b0;
      idleInputs();

      vecs[0] = '{x: 0,  y: 0,  w: 16,  h: 12,  color: 3'b100, cpuMode: 0, startAgain: 50, expN: 192, expDone: 194};
      vecs[1] = '{x: 14, y: 10, w: 5,   h: 5,   color: 3'b001, cpuMode: 0, startAgain: 0,  expN: 4,   expDone: 6};
      vecs[2] = '{x: 0,  y: 0,  w: 0,   h: 5,   color: 3'b010, cpuMode: 0, startAgain: 0,  expN: 0,   expDone: 2};
      vecs[3] = '{x: 16, y: 0,  w: 3,   h: 3,   color: 3'b101, cpuMode: 0, startAgain: 0,  expN: 0,   expDone: 2};
      vecs[4] = '{x: 2,  y: 1,  w: 3,   h: 1,   color: 3'b110, cpuMode: 1, startAgain: 0,  expN: 3,   expDone: 6};
      vecs[5] = '{x: 10, y: 11, w: 250, h: 255, color: 3'b111, cpuMode: 0, startAgain: 0,  expN: 6,   expDone: 8};
      vecs[6] = '{x: 0,  y: 12, w: 4,   h: 4,   color: 3'b011, cpuMode: 0, startAgain: 0,  expN: 0,   expDone: 2};

      // Reset state, including CPU pass-through while held in reset.
      repeat (2) @(negedge Clock);
      #1;
      checkOutput("rstWe", {31'd0, oWriteEnable}, 32'd0);
      checkOutput("rstBusy", {31'd0, oBusy}, 32'd0);
      checkOutput("rstDone", {31'd0, oDone}, 32'd0);
      @(negedge Clock);
      iCpuWrite = 1'b1;
      iCpuAddr  = 8'd33;
      iCpuData  = 3'd6;
      #1;
      checkOutput("rstCpuPass", {20'd0, oWriteEnable, oWriteAddress, oWriteData},
                  {20'd0, 1'b1, 8'd33, 3'd6});
      @(negedge Clock);
      idleInputs();
      Reset = 1'b1;

      $display("[TB] directed table");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
                       vecs[i].cpuMode, vecs[i].startAgain, vecs[i].expN, vecs[i].expDone);
      end

      $display("[TB] randomized fills");
      for (int i = 0; i < 20; i++) begin
         applyStimulus($urandom_range(0, 20), $urandom_range(0, 14),
                       $urandom_range(0, 20), $urandom_range(0, 15),
                       3'($urandom), 2, -1, -1, -1);
      end

      // Reset mid-fill: fill is running, then reset kills it for good while
      // the CPU path keeps working.
      $display("[TB] reset mid-fill");
      @(negedge Clock);
      iFillStart = 1'b1;
      iFillColor = 3'd5;
      iFillW     = 8'd16;
      iFillH     = 8'd12;
      for (int k = 1; k <= 9; k++) begin
         @(negedge Clock);
         idleInputs();
         if (k == 5) begin
            #1;
            checkOutput("midFillWrite", {23'd0, oWriteEnable, oWriteAddress},
                        {23'd0, 1'b1, 8'd3});
         end
      end
      Reset = 1'b0;
      @(negedge Clock);
      #1;
      checkOutput("abortWe", {31'd0, oWriteEnable}, 32'd0);
      checkOutput("abortBusy", {31'd0, oBusy}, 32'd0);
      iCpuWrite = 1'b1;
      iCpuAddr  = 8'd77;
      iCpuData  = 3'd5;
      #1;
      checkOutput("abortCpuPass", {20'd0, oWriteEnable, oWriteAddress, oWriteData},
                  {20'd0, 1'b1, 8'd77, 3'd5});
      @(negedge Clock);
      idleInputs();
      Reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge Clock);
         #1;
         checkOutput("postAbortWe", {30'd0, oWriteEnable, oBusy}, 32'd0);
      end

      // A fresh fill after the abort still works.
      applyStimulus(3, 4, 2, 2, 3'b010, 0, 0, 4, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
